// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  // Supported parameter ranges
  localparam int CH_MIN = 1;
  localparam int CH_MAX = 16;
  localparam int W_MIN  = 2;
  localparam int W_MAX  = 32;

  // Reset half-period: 1 kHz output from a 50 MHz clock
  localparam int DEF_HP_DEFAULT = 25000;

  // Width of the channel-select field; at least one bit even for a single channel
  function automatic int cfg_ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active/pending half-period,
// registered divided clock and toggle pulse.
module clk_div_ch #(
  parameter int W      = 16,
  parameter int DEF_HP = 25000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_hp,
  output logic         clk_out,
  output logic         tick,
  output logic         pend
);

  localparam logic [W-1:0] HP_RST = W'(DEF_HP);

  logic [W-1:0] cnt;
  logic [W-1:0] hp;
  logic [W-1:0] nxt;
  logic [W-1:0] wr_val;
  logic         terminal;
  logic         term_run;

  // A zero half-period is meaningless, promote it to 1 (clk/2).
  // The >= compare lets a counter above a freshly shrunken hp end at once.
  always_comb begin
    wr_val   = (wr_hp == '0) ? W'(1) : wr_hp;
    terminal = (cnt >= (hp - W'(1)));
    term_run = en && terminal;
  end

  // Counter, output clock and half-period update, all on one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      hp      <= HP_RST;
      nxt     <= HP_RST;
    end else begin
      tick <= 1'b0;
      if (!en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (terminal) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
      end else begin
        cnt <= cnt + W'(1);
      end

      // New half-periods only take over on a half-period boundary (or while
      // idle) so the running half always completes at its old length.
      if (wr) begin
        nxt <= wr_val;
        if (term_run) begin
          hp   <= wr_val;
          pend <= 1'b0;
        end else begin
          pend <= 1'b1;
        end
      end else if (pend && (!en || terminal)) begin
        hp   <= nxt;
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. The top only decodes and
// range-checks the configuration write; each channel is self-contained.
//
// Handshake: cfg_wr is a one-cycle strobe with no ready; a write is always
// accepted in the cycle cfg_wr is high, and is dropped if cfg_ch >= CH.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CH     = 4,
  parameter int W      = 16,
  parameter int DEF_HP = DEF_HP_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH-1:0]            en,
  input  logic                     cfg_wr,
  input  logic [cfg_ch_w(CH)-1:0]  cfg_ch,
  input  logic [W-1:0]             cfg_hp,
  output logic [CH-1:0]            clk_out,
  output logic [CH-1:0]            tick,
  output logic [CH-1:0]            pend
);

  localparam int             CW   = cfg_ch_w(CH);
  localparam logic [CW:0]    CH_L = (CW + 1)'(CH);

  logic          cfg_ok;
  logic [CH-1:0] wr_sel;

  // Range check and one-hot decode of the write target
  always_comb begin
    cfg_ok = cfg_wr && ({1'b0, cfg_ch} < CH_L);
    wr_sel = '0;
    for (int i = 0; i < CH; i++) begin
      if (cfg_ok && (cfg_ch == CW'(i))) wr_sel[i] = 1'b1;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    clk_div_ch #(
      .W      (W),
      .DEF_HP (DEF_HP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .wr      (wr_sel[i]),
      .wr_hp   (cfg_hp),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (CH=2, W=8, DEF_HP=4), plus a CH=3
// instance whose 2-bit select can address a non-existent channel.
module tb_clk_div_multi;

  logic       clk;
  logic       rst;
  logic [1:0] en;
  logic       cfg_wr;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_hp;
  logic [1:0] clk_out, tick, pend;

  logic [2:0] en3;
  logic       cfg_wr3;
  logic [1:0] cfg_ch3;
  logic [7:0] cfg_hp3;
  logic [2:0] clk_out3, tick3, pend3;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [1:0] e_clk, e_tick, e_pend;

  clk_div_multi #(.CH(2), .W(8), .DEF_HP(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_hp(cfg_hp), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  clk_div_multi #(.CH(3), .W(8), .DEF_HP(4)) u_dut3 (
    .clk(clk), .rst(rst), .en(en3), .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch3),
    .cfg_hp(cfg_hp3), .clk_out(clk_out3), .tick(tick3), .pend(pend3)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_hp = '0;
    en3 = '0; cfg_wr3 = 1'b0; cfg_ch3 = '0; cfg_hp3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 2'b11; cfg_wr = 1'b0; cfg_ch = '0; cfg_hp = '0;
    en3 = 3'b111; cfg_wr3 = 1'b0; cfg_ch3 = '0; cfg_hp3 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (clk_out !== 2'b00) begin errors++; $display("FAIL reset_clk_out: got %b expected 00", clk_out); end
    checks++; if (tick !== 2'b00) begin errors++; $display("FAIL reset_tick: got %b expected 00", tick); end
    checks++; if (pend !== 2'b00) begin errors++; $display("FAIL reset_pend: got %b expected 00", pend); end
    checks++; if ({clk_out3, tick3, pend3} !== 9'b0) begin errors++; $display("FAIL reset_dut3: got %b expected 0", {clk_out3, tick3, pend3}); end
    rst = 1'b0; en = '0; en3 = '0;
  endtask

  // en=01 from reset: rise after 4 edges, period 8, channel 1 silent
  task automatic test_run();
    logic [7:0] got_k;
    do_reset();
    en = 2'b01;
    exp_q.delete();
    exp_q.push_back(8'd3); exp_q.push_back(8'd7);
    exp_q.push_back(8'd11); exp_q.push_back(8'd15);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      e_clk  = {1'b0, (((k + 1) / 4) % 2) == 1};
      e_tick = {1'b0, (k % 4) == 3};
      checks++; if (clk_out !== e_clk) begin errors++; $display("FAIL run_clk_out k=%0d: got %b expected %b", k, clk_out, e_clk); end
      checks++; if (tick !== e_tick) begin errors++; $display("FAIL run_tick k=%0d: got %b expected %b", k, tick, e_tick); end
      if (tick[0] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL run_tick_sb: unexpected tick at k=%0d", k);
        end else begin
          got_k = exp_q.pop_front();
          if (got_k !== 8'(k)) begin errors++; $display("FAIL run_tick_sb: tick at %0d expected at %0d", k, got_k); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL run_tick_missing: %0d ticks not seen", exp_q.size()); end
  endtask

  // Shrink hp 4->2 written at cnt=1: pend 2 cycles, current half stays 4
  task automatic test_shrink();
    do_reset();
    en = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      e_pend = {1'b0, (k == 1) || (k == 2)};
      e_tick = {1'b0, (k == 3) || (k == 5) || (k == 7) || (k == 9)};
      e_clk  = {1'b0, (k >= 3) && (((k - 3) / 2) % 2 == 0)};
      checks++; if (pend !== e_pend) begin errors++; $display("FAIL shrink_pend k=%0d: got %b expected %b", k, pend, e_pend); end
      checks++; if (tick !== e_tick) begin errors++; $display("FAIL shrink_tick k=%0d: got %b expected %b", k, tick, e_tick); end
      checks++; if (clk_out !== e_clk) begin errors++; $display("FAIL shrink_clk_out k=%0d: got %b expected %b", k, clk_out, e_clk); end
      if (k == 0) begin cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_hp = 8'd2; end
      else cfg_wr = 1'b0;
    end
  endtask

  // hp=0 on idle channel 1 becomes 1; toggles every cycle once enabled
  task automatic test_hp0();
    do_reset();
    cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_hp = 8'd0;
    @(posedge clk); #1;
    checks++; if (pend !== 2'b10) begin errors++; $display("FAIL hp0_pend_set: got %b expected 10", pend); end
    cfg_wr = 1'b0;
    @(posedge clk); #1;
    checks++; if (pend !== 2'b00) begin errors++; $display("FAIL hp0_pend_clr: got %b expected 00", pend); end
    en = 2'b10;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      e_clk = {(k % 2) == 0, 1'b0};
      checks++; if (clk_out !== e_clk) begin errors++; $display("FAIL hp0_clk_out k=%0d: got %b expected %b", k, clk_out, e_clk); end
      checks++; if (tick !== 2'b10) begin errors++; $display("FAIL hp0_tick k=%0d: got %b expected 10", k, tick); end
      checks++; if (pend !== 2'b00) begin errors++; $display("FAIL hp0_pend k=%0d: got %b expected 00", k, pend); end
    end
  endtask

  // Write hp=6 in the exact terminal cycle: applied at once, never pending
  task automatic test_terminal_write();
    do_reset();
    en = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      e_clk  = {1'b0, (k >= 3) && (k <= 8)};
      e_tick = {1'b0, (k == 3) || (k == 9)};
      checks++; if (pend !== 2'b00) begin errors++; $display("FAIL term_pend k=%0d: got %b expected 00", k, pend); end
      checks++; if (clk_out !== e_clk) begin errors++; $display("FAIL term_clk_out k=%0d: got %b expected %b", k, clk_out, e_clk); end
      checks++; if (tick !== e_tick) begin errors++; $display("FAIL term_tick k=%0d: got %b expected %b", k, tick, e_tick); end
      if (k == 2) begin cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_hp = 8'd6; end
      else cfg_wr = 1'b0;
    end
  endtask

  // Two writes before the boundary: the second (hp=2) wins
  task automatic test_last_write();
    do_reset();
    en = 2'b01;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      e_pend = {1'b0, (k == 1) || (k == 2)};
      e_clk  = {1'b0, (k == 3) || (k == 4)};
      e_tick = {1'b0, (k == 3) || (k == 5)};
      checks++; if (pend !== e_pend) begin errors++; $display("FAIL last_pend k=%0d: got %b expected %b", k, pend, e_pend); end
      checks++; if (clk_out !== e_clk) begin errors++; $display("FAIL last_clk_out k=%0d: got %b expected %b", k, clk_out, e_clk); end
      checks++; if (tick !== e_tick) begin errors++; $display("FAIL last_tick k=%0d: got %b expected %b", k, tick, e_tick); end
      cfg_ch = 1'b0;
      if (k == 0) begin cfg_wr = 1'b1; cfg_hp = 8'd6; end
      else if (k == 1) begin cfg_wr = 1'b1; cfg_hp = 8'd2; end
      else cfg_wr = 1'b0;
    end
  endtask

  // Reset in the middle of a high half with a write pending
  task automatic test_reset_mid();
    do_reset();
    en = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_hp = 8'd2;
    @(posedge clk); #1;
    checks++; if ({pend, clk_out} !== 4'b0101) begin errors++; $display("FAIL rmid_pre: got pend=%b clk_out=%b expected 01/01", pend, clk_out); end
    cfg_wr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (clk_out !== 2'b00) begin errors++; $display("FAIL rmid_clk_out: got %b expected 00", clk_out); end
    checks++; if (tick !== 2'b00) begin errors++; $display("FAIL rmid_tick: got %b expected 00", tick); end
    checks++; if (pend !== 2'b00) begin errors++; $display("FAIL rmid_pend: got %b expected 00", pend); end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      e_clk  = {1'b0, k >= 3};
      e_tick = {1'b0, k == 3};
      checks++; if (clk_out !== e_clk) begin errors++; $display("FAIL rmid_run_clk k=%0d: got %b expected %b", k, clk_out, e_clk); end
      checks++; if (tick !== e_tick) begin errors++; $display("FAIL rmid_run_tick k=%0d: got %b expected %b", k, tick, e_tick); end
    end
  endtask

  // en[0] low for 3 cycles mid-period, then a full-length restart
  task automatic test_en_drop();
    do_reset();
    en = 2'b01;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      e_clk  = {1'b0, (k == 3) || (k == 4) || (k == 11) || (k == 12)};
      e_tick = {1'b0, (k == 3) || (k == 11)};
      checks++; if (clk_out !== e_clk) begin errors++; $display("FAIL endrop_clk k=%0d: got %b expected %b", k, clk_out, e_clk); end
      checks++; if (tick !== e_tick) begin errors++; $display("FAIL endrop_tick k=%0d: got %b expected %b", k, tick, e_tick); end
      if (k == 4) en = 2'b00;
      if (k == 7) en = 2'b01;
    end
  endtask

  // Select 3 on a 3-channel instance is out of range and must be dropped
  task automatic test_range();
    do_reset();
    cfg_wr3 = 1'b1; cfg_ch3 = 2'd3; cfg_hp3 = 8'd2;
    @(posedge clk); #1;
    checks++; if ({clk_out3, tick3, pend3} !== 9'b0) begin errors++; $display("FAIL range_ignore: got %b expected 0", {clk_out3, tick3, pend3}); end
    cfg_ch3 = 2'd2;
    @(posedge clk); #1;
    checks++; if (pend3 !== 3'b100) begin errors++; $display("FAIL range_valid_pend: got %b expected 100", pend3); end
    cfg_wr3 = 1'b0;
    @(posedge clk); #1;
    checks++; if (pend3 !== 3'b000) begin errors++; $display("FAIL range_pend_clr: got %b expected 000", pend3); end
    en3 = 3'b100;
    @(posedge clk); #1;
    checks++; if (clk_out3 !== 3'b000) begin errors++; $display("FAIL range_hp2_first: got %b expected 000", clk_out3); end
    @(posedge clk); #1;
    checks++; if (clk_out3 !== 3'b100) begin errors++; $display("FAIL range_hp2_rise: got %b expected 100", clk_out3); end
    checks++; if (tick3 !== 3'b100) begin errors++; $display("FAIL range_hp2_tick: got %b expected 100", tick3); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_shrink();
    test_hp0();
    test_terminal_write();
    test_last_write();
    test_reset_mid();
    test_en_drop();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter W, default 16: half-period counter width in bits, 2..32.
REQ-003 Parameter DEF_HP, default 25000: reset half-period in clk cycles (1 kHz from 50 MHz), 1..2^W-1.
REQ-004 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  CH  per-channel run enable, level.
REQ-007 cfg_wr  input  1  one-cycle strobe writing a half-period value.
REQ-008 cfg_ch  input  $clog2(CH) (min 1)  target channel of cfg_wr.
REQ-009 cfg_hp  input  W  requested half-period in clk cycles.
REQ-010 clk_out  output  CH  divided clock per channel, registered.
REQ-011 tick  output  CH  one-cycle pulse, high in the cycle clk_out[i] toggles.
REQ-012 pend  output  CH  high while a written half-period waits to take effect.

Function
REQ-013 Each channel i shall hold hp[i] (active half-period), nxt[i] (pending value), cnt[i] (W bits), all independent of other channels.
REQ-014 When en[i]=1 and cnt[i] < hp[i]-1, cnt[i] shall increment by 1 per cycle.
REQ-015 When en[i]=1 and cnt[i] >= hp[i]-1 (terminal), cnt[i] shall clear to 0, clk_out[i] shall invert and tick[i] shall be 1 in that cycle.
REQ-016 Output period shall be 2*hp[i] cycles at 50% duty; hp=1 gives clk/2.
REQ-017 When en[i]=0, cnt[i] and clk_out[i] shall clear to 0 next cycle and tick[i] shall stay 0.
REQ-018 After en[i] rises, first clk_out[i] rising edge shall occur hp[i] cycles later (cnt counts 0..hp-1).
REQ-019 cfg_wr with cfg_ch < CH shall load nxt[cfg_ch] and set pend[cfg_ch] next cycle.
REQ-020 cfg_wr with cfg_ch >= CH shall be ignored, no state change.
REQ-021 cfg_hp = 0 shall be stored as 1.
REQ-022 Pending value shall transfer to hp[i] only at a terminal cycle (glitch-free), with pend[i] cleared in the same cycle; the current half-period completes at the old value.
REQ-023 If en[i]=0, pending value shall transfer to hp[i] on the cycle after cfg_wr.
REQ-024 cfg_wr to channel i coinciding with its terminal cycle shall apply cfg_hp immediately as the new hp[i] (no pend), old half-period still ending that cycle.
REQ-025 Repeated cfg_wr before transfer: last write wins.
REQ-026 Comparison REQ-015 uses >= so that cnt above a shrunken hp terminates next cycle; no wrap-around of cnt shall occur.

Reset
REQ-027 With rst=1 at a clk edge: cnt=0, clk_out=0, tick=0, pend=0, hp=nxt=DEF_HP on all channels.
REQ-028 Reset mid-period shall discard any pending value and restart from REQ-027 state; en sampled from the first cycle after rst falls.

Structure
REQ-029 Package clk_div_pkg shall hold DEF_HP default, CH/W limits, and a width function for cfg_ch.
REQ-030 One sub-module clk_div_ch (single channel: cnt, hp, nxt, pend, clk_out, tick) shall be instantiated CH times by generate; top does cfg_ch decode and range check only.

Verification (CH=2, W=8, DEF_HP=4)
REQ-031 Reset, en=2'b01 -> clk_out[0] rises 4 cycles after en, period 8, tick[0] every 4 cycles; clk_out[1]=0, tick[1]=0 throughout.
REQ-032 Running hp=4, cfg_wr ch0 hp=2 at cnt=1 -> pend[0]=1 until terminal (2 cycles later), that half lasts 4, following halves last 2.
REQ-033 cfg_wr ch1 hp=0 with en[1]=0, then en[1]=1 -> hp=1, clk_out[1] toggles every cycle, pend[1] high one cycle only.
REQ-034 cfg_wr ch0 hp=6 in the exact terminal cycle -> no pend, next half-period 6; cfg_wr cfg_ch=3 -> no change on any output.
REQ-035 rst asserted mid-period with pending write on ch0 -> all outputs 0, pend=0, next run uses hp=4.
REQ-036 en[0] dropped mid-period for 3 cycles then raised -> clk_out[0]=0 during low, restart gives full 4-cycle first half.
